// File: rtl/pla_sat_scanner.sv
// Programmable sum-of-products (PLA) with a streaming evaluate path and an exhaustive SAT scanner.
// Evaluate: 1-cycle latency, 1 vector/cycle. Scan: first SAT at assignment k -> done k+2 cycles after start.
// Backpressure: out_ready low holds z/out_valid and drops in_ready; in_ready is also low while scanning.
module pla_sat_scanner #(
  parameter int N_IN    = 26,
  parameter int N_OUT   = 11,
  parameter int N_TERMS = 64,
  localparam int TW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1,
  localparam int SW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [TW-1:0]    cfg_term,
  input  logic [N_IN-1:0]  cfg_care,
  input  logic [N_IN-1:0]  cfg_pol,
  input  logic [N_OUT-1:0] cfg_omask,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] z,
  input  logic             start,
  input  logic [SW-1:0]    sel,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             sat,
  output logic [N_IN-1:0]  witness,
  output logic             aborted
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Row index / output select bounds, one bit wider so the full range compares cleanly.
  localparam logic [TW:0] NT_L = (TW+1)'(N_TERMS);
  localparam logic [SW:0] NO_L = (SW+1)'(N_OUT);

  state_t state, state_nxt;

  logic [N_IN-1:0]  care_r  [N_TERMS];
  logic [N_IN-1:0]  pol_r   [N_TERMS];
  logic [N_OUT-1:0] omask_r [N_TERMS];

  logic [N_IN-1:0]  cnt;
  logic [SW-1:0]    sel_r;
  logic [N_OUT-1:0] z_eval, z_scan;
  logic             hit, last, term_ok, sel_ok, start_ok;

  assign term_ok  = ({1'b0, cfg_term} < NT_L);
  assign sel_ok   = ({1'b0, sel} < NO_L);
  assign start_ok = (state != SCAN) && start && !out_valid && !in_valid;
  assign hit      = z_scan[sel_r];
  assign last     = (cnt == '1);

  // Evaluate the PLA twice in parallel: once for the eval vector, once for the scan counter.
  always_comb begin
    z_eval = '0;
    z_scan = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      if (&((x ~^ pol_r[t]) | ~care_r[t]))   z_eval = z_eval | omask_r[t];
      if (&((cnt ~^ pol_r[t]) | ~care_r[t])) z_scan = z_scan | omask_r[t];
    end
  end

  // Row storage: writes only land outside a scan and for an existing row; otherwise flag an error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
      for (int t = 0; t < N_TERMS; t++) begin
        care_r[t]  <= '0;
        pol_r[t]   <= '0;
        omask_r[t] <= '0;
      end
    end else begin
      cfg_err <= cfg_we && ((state == SCAN) || !term_ok);
      if (cfg_we && (state != SCAN) && term_ok) begin
        care_r[cfg_term]  <= cfg_care;
        pol_r[cfg_term]   <= cfg_pol;
        omask_r[cfg_term] <= cfg_omask;
      end
    end
  end

  // Eval output register: load on transfer, hold until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      z         <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      z         <= z_eval;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Scan FSM next state: abort, hit and terminal count all end the scan.
  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:    if (abort || hit || last) state_nxt = DONE;
      default: if (start_ok)             state_nxt = SCAN;
    endcase
  end

  // Scan FSM outputs; eval input is blocked while scanning or while the result slot is full.
  always_comb begin
    busy     = (state == SCAN);
    done     = (state == DONE);
    in_ready = rst_n && (state != SCAN) && (!out_valid || out_ready);
  end

  // Scan datapath: counter, captured select and held results. Terminal compare precedes increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      sel_r   <= '0;
      sat     <= 1'b0;
      witness <= '0;
      aborted <= 1'b0;
    end else if (state == SCAN) begin
      if (abort) begin
        aborted <= 1'b1;
      end else if (hit) begin
        sat     <= 1'b1;
        witness <= cnt;
      end else if (!last) begin
        cnt <= cnt + 1'b1;
      end
    end else if (start_ok) begin
      cnt     <= '0;
      sel_r   <= sel_ok ? sel : '0;
      sat     <= 1'b0;
      witness <= '0;
      aborted <= 1'b0;
    end
  end

endmodule
